// File: rtl/json_token_serializer_if.sv
// Token-in / byte-out / error-status bundle for json_token_serializer.
// The serializer takes the slave side and the token source takes the master side.
interface json_token_serializer_if #(parameter int NUM_W = 32);
  logic             tok_valid;
  logic             tok_ready;
  logic [3:0]       tok_type;
  logic [NUM_W-1:0] tok_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             err_valid;
  logic [2:0]       err_code;

  modport master (output tok_valid, tok_type, tok_data, out_ready,
                  input  tok_ready, out_valid, out_data, out_last, err_valid, err_code);
  modport slave  (input  tok_valid, tok_type, tok_data, out_ready,
                  output tok_ready, out_valid, out_data, out_last, err_valid, err_code);
endinterface

// File: rtl/json_token_serializer.sv
// Turns a JSON token stream into compact ASCII text, one byte per beat, with
// automatic separators, string escaping, decimal numbers and a bounded nesting stack.
//
// state    | meaning
// IDLE     | waiting for the next token
// SEP      | emitting ',' or ':' ahead of the pending token bytes
// LIT      | emitting a literal, quote or bracket from the ROM
// NUM_CONV | divide-by-10 loop filling the digit buffer
// NUM_EMIT | emitting digits, most significant first
// STR_ESC  | emitting a string byte, with a '\' prefix when needed
// ERR      | sticky error; no tokens accepted, no bytes emitted
module json_token_serializer #(
  parameter int MAX_DEPTH = 8,
  parameter int NUM_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  json_token_serializer_if.slave bus
);
  localparam int            DW    = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0] D_MAX = DW'(MAX_DEPTH);
  localparam logic [3:0] T_NUM = 4'd3, T_STR_BEGIN = 4'd4, T_STR_CHAR = 4'd5,
                         T_STR_END = 4'd6, T_OBJ_BEGIN = 4'd7, T_OBJ_END = 4'd8,
                         T_ARR_BEGIN = 4'd9, T_ARR_END = 4'd10;

  typedef enum logic [2:0] {S_IDLE, S_SEP, S_LIT, S_NUM_CONV, S_NUM_EMIT, S_STR_ESC, S_ERR} state_t;

  state_t           r_state, w_state_nx, r_after, w_after_nx;
  logic             r_init;
  logic [7:0]       r_sep, w_sep_nx, r_chr, w_chr_nx;
  logic [2:0]       r_sel, w_sel_nx, r_idx, w_idx_nx;
  logic             r_last, w_last_nx, r_esc, w_esc_nx;
  logic [NUM_W-1:0] r_quot, w_quot_nx, w_q10;
  logic [3:0]       r_dig [10];
  logic [3:0]       w_dig_nx [10];
  logic [3:0]       r_ndig, w_ndig_nx, w_digit, w_dig_cur;
  logic [MAX_DEPTH-1:0] r_obj, w_obj_nx, r_first, w_first_nx, r_expv, w_expv_nx;
  logic [DW-1:0]    r_depth, w_depth_nx, w_done_lvl;
  logic             r_in_str, w_in_str_nx, r_is_key, w_is_key_nx, r_root_done, w_root_done_nx;
  logic [2:0]       r_err_code, w_err_code_nx;
  logic             w_top_obj, w_top_first, w_top_expv;
  logic             w_is_val, w_bad, w_need_sep, w_val_done;
  logic [7:0]       w_sep_byte, w_out_data;
  logic             w_out_valid, w_out_last;
  state_t           w_emit;
  logic [3:0]       w_t;

  function automatic logic [7:0] lit_byte(input logic [2:0] sel, input logic [2:0] idx);
    logic [39:0] s;
    case (sel)
      3'd0:    s = {"null", 8'h00};
      3'd1:    s = {"true", 8'h00};
      3'd2:    s = "false";
      3'd3:    s = {8'h22, 32'h0};
      3'd4:    s = {8'h7B, 32'h0};
      3'd5:    s = {8'h7D, 32'h0};
      3'd6:    s = {8'h5B, 32'h0};
      default: s = {8'h5D, 32'h0};
    endcase
    return 8'(s >> (6'd32 - {idx, 3'b000}));
  endfunction

  function automatic logic [2:0] lit_len(input logic [2:0] sel);
    case (sel)
      3'd0, 3'd1: return 3'd4;
      3'd2:       return 3'd5;
      default:    return 3'd1;
    endcase
  endfunction

  assign w_t     = bus.tok_type;
  assign w_q10   = r_quot / NUM_W'(10);
  assign w_digit = 4'(r_quot % NUM_W'(10));

  always_comb begin
    w_top_obj = 1'b0; w_top_first = 1'b0; w_top_expv = 1'b0; w_dig_cur = 4'd0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (i == int'(r_depth) - 1) begin
        w_top_obj = r_obj[i]; w_top_first = r_first[i]; w_top_expv = r_expv[i];
      end
    end
    for (int i = 0; i < 10; i++) if (i == int'(r_ndig)) w_dig_cur = r_dig[i];
  end

  always_comb begin
    w_state_nx = r_state; w_after_nx = r_after; w_sep_nx = r_sep; w_sel_nx = r_sel;
    w_idx_nx = r_idx; w_last_nx = r_last; w_quot_nx = r_quot; w_dig_nx = r_dig;
    w_ndig_nx = r_ndig; w_chr_nx = r_chr; w_esc_nx = r_esc; w_obj_nx = r_obj;
    w_first_nx = r_first; w_expv_nx = r_expv; w_depth_nx = r_depth; w_in_str_nx = r_in_str;
    w_is_key_nx = r_is_key; w_root_done_nx = r_root_done; w_err_code_nx = r_err_code;
    w_out_valid = 1'b0; w_out_data = 8'h00; w_out_last = 1'b0;
    w_bad = 1'b0; w_need_sep = 1'b0; w_sep_byte = 8'h2C; w_val_done = 1'b0;
    w_done_lvl = r_depth; w_emit = S_LIT;
    w_is_val = (w_t <= T_ARR_BEGIN) && (w_t != T_STR_CHAR) && (w_t != T_STR_END) && (w_t != T_OBJ_END);
    case (r_state)
      S_IDLE: if (r_init && bus.tok_valid) begin
        if (r_in_str) begin
          w_bad = !(w_t == T_STR_CHAR || w_t == T_STR_END) ||
                  (w_t == T_STR_CHAR && bus.tok_data[7:0] < 8'h20);
        end else if (r_depth == '0) begin
          w_bad = !w_is_val;
        end else if (w_top_obj && !w_top_expv) begin
          w_bad      = !(w_t == T_STR_BEGIN || w_t == T_OBJ_END);
          w_need_sep = (w_t == T_STR_BEGIN) && !w_top_first;
        end else if (w_top_obj) begin
          w_bad = !w_is_val; w_need_sep = 1'b1; w_sep_byte = 8'h3A;
        end else begin
          w_bad      = !(w_is_val || w_t == T_ARR_END);
          w_need_sep = w_is_val && !w_top_first;
        end
        if (!r_in_str && r_depth == '0 && r_root_done) begin
          w_state_nx = S_ERR; w_err_code_nx = 3'd3;
        end else if (w_bad) begin
          w_state_nx = S_ERR; w_err_code_nx = 3'd1;
        end else if ((w_t == T_OBJ_BEGIN || w_t == T_ARR_BEGIN) && r_depth == D_MAX) begin
          w_state_nx = S_ERR; w_err_code_nx = 3'd5;
        end else begin
          // elements of an array and keys of an object consume the first-element slot
          if (!r_in_str && r_depth != '0 && w_is_val && !(w_top_obj && w_top_expv))
            for (int i = 0; i < MAX_DEPTH; i++) if (i == int'(r_depth) - 1) w_first_nx[i] = 1'b0;
          w_last_nx = 1'b0; w_idx_nx = 3'd0;
          case (w_t)
            T_NUM: begin
              w_quot_nx = bus.tok_data; w_ndig_nx = 4'd0; w_emit = S_NUM_CONV; w_val_done = 1'b1;
            end
            T_STR_BEGIN: begin
              w_sel_nx = 3'd3; w_in_str_nx = 1'b1;
              w_is_key_nx = (r_depth != '0) && w_top_obj && !w_top_expv;
            end
            T_STR_CHAR: begin
              w_chr_nx = bus.tok_data[7:0]; w_emit = S_STR_ESC;
              w_esc_nx = (bus.tok_data[7:0] == 8'h22) || (bus.tok_data[7:0] == 8'h5C);
            end
            T_STR_END: begin
              w_sel_nx = 3'd3; w_in_str_nx = 1'b0;
              if (r_is_key) begin
                for (int i = 0; i < MAX_DEPTH; i++) if (i == int'(r_depth) - 1) w_expv_nx[i] = 1'b1;
              end else w_val_done = 1'b1;
            end
            T_OBJ_BEGIN, T_ARR_BEGIN: begin
              w_sel_nx = (w_t == T_OBJ_BEGIN) ? 3'd4 : 3'd6;
              w_depth_nx = r_depth + DW'(1);
              for (int i = 0; i < MAX_DEPTH; i++) begin
                if (i == int'(r_depth)) begin
                  w_obj_nx[i] = (w_t == T_OBJ_BEGIN); w_first_nx[i] = 1'b1; w_expv_nx[i] = 1'b0;
                end
              end
            end
            T_OBJ_END, T_ARR_END: begin
              w_sel_nx = (w_t == T_OBJ_END) ? 3'd5 : 3'd7;
              w_depth_nx = r_depth - DW'(1); w_done_lvl = r_depth - DW'(1); w_val_done = 1'b1;
            end
            default: begin
              w_sel_nx = w_t[2:0]; w_val_done = 1'b1;
            end
          endcase
          if (w_val_done) begin
            if (w_done_lvl == '0) begin
              w_root_done_nx = 1'b1; w_last_nx = 1'b1;
            end else begin
              for (int i = 0; i < MAX_DEPTH; i++) if (i == int'(w_done_lvl) - 1) w_expv_nx[i] = 1'b0;
            end
          end
          w_sep_nx   = w_sep_byte;
          w_after_nx = w_emit;
          w_state_nx = w_need_sep ? S_SEP : w_emit;
        end
      end
      S_SEP: begin
        w_out_valid = 1'b1; w_out_data = r_sep;
        if (bus.out_ready) w_state_nx = r_after;
      end
      S_LIT: begin
        w_out_valid = 1'b1; w_out_data = lit_byte(r_sel, r_idx);
        w_out_last  = r_last && (r_idx == lit_len(r_sel) - 3'd1);
        if (bus.out_ready) begin
          if (r_idx == lit_len(r_sel) - 3'd1) w_state_nx = S_IDLE;
          else w_idx_nx = r_idx + 3'd1;
        end
      end
      S_NUM_CONV: begin
        for (int i = 0; i < 10; i++) if (i == int'(r_ndig)) w_dig_nx[i] = w_digit;
        w_quot_nx = w_q10;
        if (w_q10 == '0) w_state_nx = S_NUM_EMIT;
        else w_ndig_nx = r_ndig + 4'd1;
      end
      S_NUM_EMIT: begin
        w_out_valid = 1'b1; w_out_data = 8'h30 + {4'h0, w_dig_cur};
        w_out_last  = r_last && (r_ndig == 4'd0);
        if (bus.out_ready) begin
          if (r_ndig == 4'd0) w_state_nx = S_IDLE;
          else w_ndig_nx = r_ndig - 4'd1;
        end
      end
      S_STR_ESC: begin
        w_out_valid = 1'b1; w_out_data = r_esc ? 8'h5C : r_chr;
        if (bus.out_ready) begin
          if (r_esc) w_esc_nx = 1'b0;
          else w_state_nx = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE; r_after <= S_IDLE; r_init <= 1'b0; r_sep <= '0; r_chr <= '0;
      r_sel <= '0; r_idx <= '0; r_last <= 1'b0; r_esc <= 1'b0; r_quot <= '0; r_ndig <= '0;
      for (int i = 0; i < 10; i++) r_dig[i] <= '0;
      r_obj <= '0; r_first <= '0; r_expv <= '0; r_depth <= '0; r_in_str <= 1'b0;
      r_is_key <= 1'b0; r_root_done <= 1'b0; r_err_code <= '0;
    end else begin
      r_state <= w_state_nx; r_after <= w_after_nx; r_init <= 1'b1; r_sep <= w_sep_nx;
      r_chr <= w_chr_nx; r_sel <= w_sel_nx; r_idx <= w_idx_nx; r_last <= w_last_nx;
      r_esc <= w_esc_nx; r_quot <= w_quot_nx; r_ndig <= w_ndig_nx; r_dig <= w_dig_nx;
      r_obj <= w_obj_nx; r_first <= w_first_nx; r_expv <= w_expv_nx; r_depth <= w_depth_nx;
      r_in_str <= w_in_str_nx; r_is_key <= w_is_key_nx; r_root_done <= w_root_done_nx;
      r_err_code <= w_err_code_nx;
    end
  end

  assign bus.tok_ready = r_init && (r_state == S_IDLE);
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_last  = w_out_last;
  assign bus.err_valid = (r_state == S_ERR);
  assign bus.err_code  = r_err_code;
endmodule
